// File: rtl/cpu_pkg.sv
// Shared types and default widths for the CPU memory path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Arbiter ownership of the single RAM port.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_fair.sv
// Saturating run counter of MEM grants taken while IF was waiting.
// Latency: counter updates at the clock edge; sat is combinational from the count.
// Backpressure: none; inc is ignored once saturated, clr has priority over inc.
//
// Ports: clk/rst (async active-high), inc (MEM grant while IF eligible),
//        clr (IF grant, or MEM grant with no IF request), sat (run limit reached).
module mem_arb_fair #(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);

  logic [RUN_W-1:0] r_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run <= '0;
    end else if (clr) begin
      r_run <= '0;
    end else if (inc && !sat) begin
      r_run <= r_run + RUN_W'(1);
    end
  end

  assign sat = (r_run == RUN_W'(MAX_DATA_RUN));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported unified RAM between instruction fetch (IF) and load/store (MEM).
// Latency: request in cycle N -> registered ram_req in N+1; ack combinational with ram_ready (earliest N+1).
// Backpressure: requesters hold req until ack; one IDLE cycle between accesses (max 1 access / 2 cycles).
//
// Ports: clk, rst (async active-high);
//        IF side : if_req, if_addr, if_abort -> if_ack, if_rdata
//        MEM side: mem_req, mem_we, mem_addr, mem_wdata, mem_be -> mem_ack, mem_rdata
//        RAM side: ram_req, ram_we, ram_addr, ram_wdata, ram_be (registered) <- ram_rdata, ram_ready
// Build option: define MEM_ARB_FAIRNESS_EN to let IF win after MAX_DATA_RUN consecutive
//        MEM grants taken while IF was waiting; otherwise MEM always has strict priority.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_abort,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_be,
  output logic                mem_ack,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                ram_req,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_be,
  input  logic [DATA_W-1:0]   ram_rdata,
  input  logic                ram_ready
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_abort_pend;
  logic       w_if_elig;
  logic       w_grant_if;
  logic       w_grant_mem;
  logic       w_fair_sat;

  // A redirect in the same cycle makes the current fetch address stale.
  assign w_if_elig = if_req & ~if_abort;

`ifdef MEM_ARB_FAIRNESS_EN
  mem_arb_fair #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_fair (
    .clk (clk),
    .rst (rst),
    .inc (w_grant_mem & w_if_elig),
    .clr (w_grant_if | (w_grant_mem & ~if_req)),
    .sat (w_fair_sat)
  );
`else
  // Strict MEM priority: IF never preempts a pending MEM request.
  assign w_fair_sat = (MAX_DATA_RUN < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    if_ack      = 1'b0;
    mem_ack     = 1'b0;
    if_rdata    = '0;
    mem_rdata   = '0;
    case (r_state)
      IDLE: begin
        if (w_if_elig && (!mem_req || w_fair_sat)) begin
          w_grant_if  = 1'b1;
          w_state_nxt = BUSY_IF;
        end else if (mem_req) begin
          w_grant_mem = 1'b1;
          w_state_nxt = BUSY_MEM;
        end
      end
      BUSY_IF: begin
        if (ram_ready) begin
          w_state_nxt = IDLE;
          // An abort earlier in the access or in this very cycle discards the fetch.
          if (!r_abort_pend && !if_abort) begin
            if_ack   = 1'b1;
            if_rdata = ram_rdata;
          end
        end
      end
      BUSY_MEM: begin
        if (ram_ready) begin
          w_state_nxt = IDLE;
          mem_ack     = 1'b1;
          mem_rdata   = ram_rdata;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_abort_pend <= 1'b0;
    end else if (w_state_nxt == IDLE) begin
      r_abort_pend <= 1'b0;
    end else if (r_state == BUSY_IF && if_abort) begin
      r_abort_pend <= 1'b1;
    end
  end

  // Command register: loaded on a grant, held through the access, request dropped on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_be    <= '0;
    end else if (w_grant_if) begin
      ram_req   <= 1'b1;
      ram_we    <= 1'b0;
      ram_addr  <= if_addr;
      ram_wdata <= '0;
      ram_be    <= '0;
    end else if (w_grant_mem) begin
      ram_req   <= 1'b1;
      ram_we    <= mem_we;
      ram_addr  <= mem_addr;
      ram_wdata <= mem_wdata;
      ram_be    <= mem_be;
    end else if (r_state != IDLE && ram_ready) begin
      ram_req   <= 1'b0;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-ported unified instruction/data memory between the pipeline's IF stage (instruction fetch) and MEM stage (load/store). Each side uses a request/acknowledge handshake. The arbiter owns a registered command bus to the RAM and holds it stable until the RAM signals completion. It sits between the CPU pipeline registers and the memory model, and supplies the stall conditions both stages use.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- MAX_DATA_RUN, 4, consecutive MEM grants allowed while IF waits (fairness build only)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until if_ack or abort
- if_addr  in  ADDR_W  fetch address
- if_abort  in  1  branch redirect; discard any in-flight fetch
- if_ack  out  1  fetch complete, if_rdata valid this cycle
- if_rdata  out  DATA_W  fetched instruction
- mem_req  in  1  load/store request, held until mem_ack
- mem_we  in  1  1 = store
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_be  in  DATA_W/8  byte enables
- mem_ack  out  1  access complete, mem_rdata valid this cycle
- mem_rdata  out  DATA_W  load data
- ram_req, ram_we, ram_addr, ram_wdata, ram_be  out  registered command to RAM
- ram_rdata  in  DATA_W  RAM read data, valid with ram_ready
- ram_ready  in  1  RAM completion, only while ram_req is high

## Operation
- States are IDLE, BUSY_IF and BUSY_MEM.
- **IDLE:** selects a winner among the pending requests and loads ram_* from that requester's inputs at the clock edge.
  - The next state is BUSY_IF or BUSY_MEM.
  - ram_we, ram_wdata and ram_be are forced to 0 for fetches.
  - With no requests pending, the arbiter stays in IDLE with ram_req = 0.
- **Priority:** MEM wins over IF because it holds the older instruction. Exception: the fairness rule below.
- **BUSY_x:** ram_* held stable.
  - On ram_ready: the requester's ack = 1 combinationally in the same cycle. Its rdata is passed through from ram_rdata. ram_req drops at the edge and the state returns to IDLE.
- **Abort:**
  - if_abort during BUSY_IF sets abort_pend. The RAM transaction still completes, but if_ack is suppressed. abort_pend clears on return to IDLE.
  - if_abort in IDLE blocks the IF grant for that cycle.
- **ack rules:** if_ack and mem_ack are never both high. An ack never occurs without a matching ram_ready.
- **Stalls:** stall outputs are not ports. The pipeline derives its stall as req & ~ack.
- **Writes:** for stores, mem_rdata is don't-care and mem_ack still pulses.

## Timing
- **Reset values:** state IDLE, ram_req 0, all ram_* 0, if_ack 0, mem_ack 0, rdata outputs 0, counter 0, abort_pend 0.
- **Reset mid-operation:** ram_req drops asynchronously and the outstanding RAM access is abandoned. The RAM must tolerate a dropped request.
- **Latency:**
  - A request first high in cycle N gives ram_req high in cycle N+1.
  - The ack comes in the first cycle with ram_ready, at the earliest N+1.
- **Throughput:** one IDLE cycle between accesses, so at most one access per 2 cycles.
- **Back-to-back:** a requester that drops req at the ack edge is not re-granted. A requester that keeps req high issues a new access.
- **Simultaneous events:**
  - if_abort and ram_ready in the same BUSY_IF cycle: the ack is suppressed.
  - Both requests in IDLE: MEM wins, unless the fairness rule applies.

## Configuration
- **MEM_ARB_FAIRNESS_EN defined:** a counter `run` of width $clog2(MAX_DATA_RUN+1) is kept.
  - It increments on each MEM grant while if_req is high and if_abort is low, and saturates.
  - It clears on an IF grant, or on a MEM grant with if_req low.
  - When run == MAX_DATA_RUN and IF is eligible, IF wins over MEM.
- **MEM_ARB_FAIRNESS_EN undefined:** strict MEM priority; the counter logic is absent.

## Structure
- cpu_pkg holds:
  - the arb_state_t enum {IDLE, BUSY_IF, BUSY_MEM}
  - the default ADDR_W and DATA_W constants
- The fairness counter is the natural sub-module, mem_arb_fair, with ports inc, clr and sat. It is instantiated only under MEM_ARB_FAIRNESS_EN.
- The FSM, command register and ack/rdata muxing stay in mem_arbiter.

## Test plan
- **Single fetch:** if_req=1, if_addr=0x10, RAM returns ready 2 cycles after ram_req with rdata 0x00A00093 -> ram_addr=0x10 and ram_we=0 from the cycle after the request; one if_ack pulse; if_rdata=0x00A00093.
- **Contention:** if_req and mem_req (store, addr 0x200, wdata 0xDEADBEEF, be 0xF) asserted together -> store granted first, ram_we=1, mem_ack; then the fetch is granted after one IDLE cycle.
- **Abort:** fetch in BUSY_IF, if_abort pulsed one cycle, ready arrives 3 cycles later -> no if_ack; the arbiter returns to IDLE; a new fetch to 0x40 then completes normally.
- **Fairness (macro on, MAX_DATA_RUN=4):** mem_req and if_req held high continuously -> grant order M,M,M,M,I,M,… With the macro off -> the IF fetch is never granted during the run.
- **Async reset:** assert rst mid BUSY_MEM, between clock edges -> ram_req=0 immediately; no ack; all outputs at reset values; normal operation after deassert.
- **Back-to-back loads:** mem_req held for addresses 0x100 then 0x104, RAM ready in the first cycle -> mem_ack every second cycle; ram_req low exactly one cycle between the two accesses.
